seq_scan_ctrl: RTL and testbench
================================

# seq_scan_ctrl

Frame-level controller for the serial pattern detector. It accepts parallel words over a valid/ready stream and serializes them MSB-first into an embedded programmable bit matcher. It counts pattern hits across the whole frame, including patterns that span word boundaries, and signals frame completion. It sits between a byte-oriented producer and the detection/status logic. It replaces hand-driven bit stimulus with a sequenced, configurable scan.

## Interface
- WORD_W, 8, width of an input word; serialized MSB first
- PAT_W, 4, pattern length in bits (2..8)
- CNT_W, 16, match counter width; the counter saturates
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse in IDLE; latches config and begins a frame
- abort  input  1  synchronous; returns to IDLE from any state, no done
- cfg_pattern  input  PAT_W  pattern to detect; bit PAT_W-1 arrives first
- cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping
- s_valid  input  1  word valid
- s_data  input  WORD_W  word
- s_last  input  1  word is last of frame; qualified with s_valid
- s_ready  output  1  controller accepts word this cycle
- bit_out  output  1  serial bit currently presented to matcher
- bit_valid  output  1  bit_out valid this cycle
- hit  output  1  one-cycle pulse per detected pattern
- match_count  output  CNT_W  hits in current/last frame
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at frame end

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: s_ready=0. When start=1, latch cfg_pattern and cfg_overlap, clear match_count, clear matcher history and fill count, then go to LOAD. Config changes mid-frame are ignored.
- LOAD: s_ready=1. On s_valid&s_ready, capture s_data and s_last, load bit index = WORD_W-1, and go to SHIFT.
- SHIFT: bit_valid=1, bit_out=word[index], one bit per cycle.
  - On index 0 with last=1, go to DONE.
  - On index 0 with last=0, s_ready=1 in this same cycle (no bubble). If a word is accepted, reload and stay in SHIFT. Otherwise go to LOAD.
- DONE: done=1 for one cycle, then IDLE.
- Matcher (seq_bit_matcher):
  - Holds a PAT_W-bit history shift register and a fill count that saturates at PAT_W.
  - On each valid bit, form {history[PAT_W-2:0], bit}. A match occurs when this equals the pattern and fill+1 ≥ PAT_W.
  - On a match with overlap=1, history continues unchanged.
  - On a match with overlap=0, fill resets to 0 so the next match needs PAT_W fresh bits.
  - History is retained across words and LOAD stalls within a frame, and cleared only at start.
- match_count increments on each hit and saturates at 2^CNT_W-1. It holds its value in IDLE until the next start.
- abort: go to IDLE next edge. In-flight word is discarded, no done, match_count is held, and the pending hit for the current bit is suppressed.
- s_valid outside LOAD/final-SHIFT cycle: not accepted; the producer must hold.

## Timing
- Reset values: s_ready 0, bit_out 0, bit_valid 0, hit 0, match_count 0, busy 0, done 0. FSM is in IDLE with matcher cleared.
- Reset asserted mid-frame returns the block to these values immediately, regardless of clk.
- start → first s_ready: 1 cycle (LOAD entered next edge).
- Word accept → first bit_valid: 1 cycle.
- Back-to-back words produce continuous bit_valid with no gap.
- hit is registered: it is high the cycle after the matching bit's bit_valid cycle. match_count shows the incremented value in that same cycle.
- done coincides with the hit slot of the frame's final bit, so match_count is final when done=1.
- start and abort asserted in the same cycle: abort wins and the block stays in IDLE.

## Structure
- Package seq_det_pkg: FSM state enum (IDLE/LOAD/SHIFT/DONE, 2-bit) and default width constants.
- Sub-module seq_bit_matcher: history register, fill count, overlap handling, registered hit. Ports are clk, rst_n, clear, bit_in, bit_valid, pattern, overlap, hit.
- Top level holds the FSM, word/index register, handshake, and saturating counter.

## Test plan
- Overlap: pattern 4'b1011, overlap=1, single word 0xB6 with last=1. Required: hits after bits 3 and 6, match_count=2, done one cycle after the 8th bit.
- Non-overlap: same pattern and word, overlap=0. Required: one hit, match_count=1.
- Cross-word: pattern 4'b1011, words 0x01 then 0x60 (last). Required: no bit_valid gap, one hit on the 3rd bit of word 2, match_count=1.
- Backpressure: s_valid for word 2 delayed 3 cycles. Required: FSM sits in LOAD with bit_valid=0, history is kept, and the cross-word hit still occurs.
- Saturation: CNT_W=2, pattern 4'b1111, overlap=1, word 0xFF. Required: 5 hit pulses, match_count=3.
- Abort and reset: abort on the 4th SHIFT bit gives IDLE next cycle, no done, no further hit, and s_valid ignored. A later rst_n low mid-frame forces all outputs to reset values asynchronously.

Source files
------------

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the serial pattern detector slice:
//   - state_t      : frame controller FSM encoding (IDLE/LOAD/SHIFT/DONE)
//   - *_DEF        : default widths for word, pattern and match counter
//   - idx_width()  : width of a bit index into a word of a given size
// -----------------------------------------------------------------------------
package seq_det_pkg;

    localparam int WORD_W_DEF = 8;
    localparam int PAT_W_DEF  = 4;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A one-bit word still needs a one-bit index signal.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_bit_matcher.sv
// -----------------------------------------------------------------------------
// seq_bit_matcher
// Programmable serial bit matcher. Bits arrive one per valid cycle, oldest
// first; the pattern's MSB is compared against the oldest bit of the window.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous clear of history, fill count and hit
//   bit_in     in   serial bit
//   bit_valid  in   bit_in is valid this cycle
//   pattern    in   PAT_W-bit pattern to detect
//   overlap    in   1 = overlapping matches allowed
//   hit        out  registered match pulse, one cycle after the matching bit
// -----------------------------------------------------------------------------
module seq_bit_matcher
    import seq_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             hit
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              hit_q, hit_d;
    logic [PAT_W-1:0]  window;
    logic              match;

    always_comb begin
        window = {hist_q[PAT_W-2:0], bit_in};
        // fill+1 >= PAT_W rewritten as fill >= PAT_W-1 to stay in FILL_W bits.
        match  = bit_valid && (window == pattern) && (fill_q >= FILL_ARM);

        hist_d = hist_q;
        fill_d = fill_q;
        hit_d  = 1'b0;

        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bit_valid) begin
            hist_d = window;
            hit_d  = match;
            // Non-overlapping mode: a match consumes its bits, so the next
            // candidate must be built from PAT_W fresh bits.
            if (match && !overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
            hit_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            hit_q  <= hit_d;
        end
    end

    assign hit = hit_q;

endmodule

// File: rtl/seq_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seq_scan_ctrl
// Frame-level scan controller: accepts parallel words on a valid/ready stream,
// serializes them MSB first into seq_bit_matcher, counts hits across the frame
// (including patterns spanning word boundaries) and pulses done at frame end.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 pulse in IDLE: latch config, clear count, begin frame
//   abort                 return to IDLE from any state, no done
//   cfg_pattern/overlap   matcher configuration, latched at start
//   s_valid/s_data/s_last input word stream (s_last marks final word)
//   s_ready               word accepted this cycle when s_valid is also high
//   bit_out/bit_valid     serial bit presented to the matcher
//   hit                   one-cycle pulse per detected pattern
//   match_count           saturating hit count for current/last frame
//   busy                  controller not idle
//   done                  one-cycle pulse at frame end (count is final)
// -----------------------------------------------------------------------------
module seq_scan_ctrl
    import seq_det_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int PAT_W  = PAT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              cfg_overlap,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              hit,
    output logic [CNT_W-1:0]  match_count,
    output logic              busy,
    output logic              done
);

    localparam int               IDX_W   = idx_width(WORD_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              last_q, last_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              ovl_q, ovl_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic start_go;
    logic idx_zero;
    logic accept;
    logic m_valid;
    logic m_clear;
    logic m_hit;

    // A start that coincides with abort is ignored entirely.
    always_comb begin
        start_go = (state_q == IDLE) && start && !abort;
        idx_zero = (idx_q == '0);
        accept   = s_valid && s_ready;
    end

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = LOAD;
                LOAD:    if (accept) state_d = SHIFT;
                SHIFT: begin
                    if (idx_zero) begin
                        if (last_q)      state_d = DONE;
                        else if (accept) state_d = SHIFT;
                        else             state_d = LOAD;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- FSM: outputs
    always_comb begin
        s_ready   = 1'b0;
        bit_valid = 1'b0;
        bit_out   = 1'b0;
        done      = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            LOAD:  s_ready = !abort;
            SHIFT: begin
                bit_valid = 1'b1;
                bit_out   = word_q[idx_q];
                // Final bit of a non-last word: take the next word in the
                // same cycle so the serial stream has no bubble.
                s_ready   = idx_zero && !last_q && !abort;
            end
            DONE:  done = !abort;
            default: ;
        endcase

        // Abort withholds the current bit so its hit never fires.
        m_valid = bit_valid && !abort;
        m_clear = start_go;

        // match_count already includes the hit being reported this cycle,
        // so the count and the hit pulse move together.
        if (m_hit && (count_q != CNT_MAX)) begin
            match_count = count_q + CNT_W'(1);
        end else begin
            match_count = count_q;
        end
    end

    assign hit = m_hit;

    // ---------------------------------------------------------------- datapath
    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        last_d  = last_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        count_d = match_count;

        if (start_go) begin
            pat_d   = cfg_pattern;
            ovl_d   = cfg_overlap;
            count_d = '0;
        end

        if (accept) begin
            word_d = s_data;
            last_d = s_last;
            idx_d  = IDX_TOP;
        end else if ((state_q == SHIFT) && !idx_zero) begin
            idx_d = idx_q - IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            count_q <= '0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            count_q <= count_d;
        end
    end

    // ---------------------------------------------------------------- matcher
    seq_bit_matcher #(
        .PAT_W (PAT_W)
    ) u_matcher (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (m_clear),
        .bit_in    (bit_out),
        .bit_valid (m_valid),
        .pattern   (pat_q),
        .overlap   (ovl_q),
        .hit       (m_hit)
    );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_scan_ctrl
// Directed and randomized frames for seq_scan_ctrl. Two instances share the
// stimulus: a default one (16-bit counter) and a 2-bit counter one for
// saturation. Expected hits come from a positional window model of the frame.
// -----------------------------------------------------------------------------
module tb_seq_scan_ctrl;

    localparam int CMAX_L = 65535;
    localparam int CMAX_S = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  cfg_pattern = '0;
    logic        cfg_overlap = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_last = 1'b0;

    logic        s_ready, bit_out, bit_valid, hit, busy, done;
    logic [15:0] match_count;
    logic        s_ready_s, bit_out_s, bit_valid_s, hit_s, busy_s, done_s;
    logic [1:0]  match_count_s;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .bit_out(bit_out), .bit_valid(bit_valid),
        .hit(hit), .match_count(match_count), .busy(busy), .done(done)
    );

    seq_scan_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready_s), .bit_out(bit_out_s), .bit_valid(bit_valid_s),
        .hit(hit_s), .match_count(match_count_s), .busy(busy_s), .done(done_s)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------ monitor
    bit   mon_en = 1'b0;
    logic obs_bits[$];
    int   obs_bit_cyc[$];
    int   obs_hit_cyc[$];
    int   obs_hit_cnt[$];
    int   done_cyc[$];
    int   done_cnt[$];
    int   hit_s_n = 0;

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (bit_valid) begin
                obs_bits.push_back(bit_out);
                obs_bit_cyc.push_back(cyc);
            end
            if (hit) begin
                obs_hit_cyc.push_back(cyc);
                obs_hit_cnt.push_back(int'(match_count));
            end
            if (done) begin
                done_cyc.push_back(cyc);
                done_cnt.push_back(int'(match_count));
            end
            if (hit_s) hit_s_n++;
        end
    end

    // ------------------------------------------------------------ frame descriptor
    logic [7:0] fr_words[16];
    int         fr_gap[16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference: a hit at bit position p if the last 4 bits equal the pattern
    // and, without overlap, at least 4 bits have passed since the previous hit.
    function automatic int model_hits(input logic [3:0] pat, input logic ovl, input int nw,
                                      output logic [63:0] bits_vec, output logic [63:0] mask);
        int nb;
        int last_p;
        int n;
        logic [3:0] win;
        nb = nw * 8;
        last_p = -100;
        n = 0;
        bits_vec = '0;
        mask = '0;
        for (int w = 0; w < nw; w++)
            for (int b = 0; b < 8; b++)
                bits_vec[w*8 + b] = fr_words[w][7-b];
        for (int p = 3; p < nb; p++) begin
            for (int j = 0; j < 4; j++) win[3-j] = bits_vec[p-3+j];
            if (win == pat && (ovl || (p - last_p) >= 4)) begin
                mask[p] = 1'b1;
                n++;
                last_p = p;
            end
        end
        return n;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {s_ready, bit_out, bit_valid, hit, busy, done}, 64'd0);
        chk({tag, "_cnt"}, match_count, 64'd0);
        chk({tag, "_ctl_s"}, {s_ready_s, bit_valid_s, hit_s, busy_s, done_s, match_count_s}, 64'd0);
    endtask

    // Runs one frame from IDLE; entered and left at #1 after a rising edge.
    task automatic run_frame(input string tag, input logic [3:0] pat, input logic ovl, input int nw);
        int t;
        int acc0;
        int nb;
        int exp_hits;
        int stray;
        bit found;
        bit no_gaps;
        logic [63:0] exp_bits, exp_mask, obs_vec, obs_mask;

        obs_bits.delete(); obs_bit_cyc.delete(); obs_hit_cyc.delete();
        obs_hit_cnt.delete(); done_cyc.delete(); done_cnt.delete();
        hit_s_n = 0;
        mon_en = 1'b1;
        acc0 = 0;
        nb = nw * 8;
        exp_hits = model_hits(pat, ovl, nw, exp_bits, exp_mask);

        cfg_pattern = pat;
        cfg_overlap = ovl;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Config must be ignored once the frame is running.
        cfg_pattern = ~pat;
        cfg_overlap = ~ovl;
        chk({tag, "_start_ready"}, {s_ready, busy, bit_valid}, 3'b110);

        for (int w = 0; w < nw; w++) begin
            s_valid = 1'b0;
            for (int k = 1; k <= fr_gap[w]; k++) begin
                @(posedge clk); #1;
                if (w == 0 || k >= 8) chk({tag, "_stall"}, {bit_valid, s_ready, busy}, 3'b011);
            end
            s_data  = fr_words[w];
            s_last  = (w == nw - 1);
            s_valid = 1'b1;
            t = 0;
            while (s_ready !== 1'b1 && t < 200) begin
                @(posedge clk); #1;
                t++;
            end
            chk({tag, "_accept_ready"}, s_ready, 1'b1);
            @(posedge clk); #1;
            if (w == 0) acc0 = cyc;
            s_valid = 1'b0;
            s_last  = 1'b0;
        end

        t = 0;
        while (done_cyc.size() == 0 && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (2) begin @(posedge clk); #1; end

        chk({tag, "_idle_after"}, {busy, s_ready}, 2'b00);
        chk({tag, "_nbits"}, obs_bits.size(), nb);
        obs_vec = '0;
        foreach (obs_bits[i]) if (i < 64) obs_vec[i] = obs_bits[i];
        chk({tag, "_bits"}, obs_vec, exp_bits);
        if (obs_bit_cyc.size() == nb) begin
            chk({tag, "_first_bit_lat"}, obs_bit_cyc[0], acc0);
            no_gaps = 1'b1;
            for (int w = 1; w < nw; w++) if (fr_gap[w] != 0) no_gaps = 1'b0;
            if (no_gaps) chk({tag, "_no_gap"}, obs_bit_cyc[nb-1] - obs_bit_cyc[0], nb - 1);
        end

        obs_mask = '0;
        stray = 0;
        foreach (obs_hit_cyc[i]) begin
            found = 1'b0;
            foreach (obs_bit_cyc[k]) begin
                if (obs_bit_cyc[k] == obs_hit_cyc[i] - 1 && k < 64) begin
                    obs_mask[k] = 1'b1;
                    found = 1'b1;
                end
            end
            if (!found) stray++;
        end
        chk({tag, "_hit_pos"}, obs_mask, exp_mask);
        chk({tag, "_hit_stray"}, stray, 0);
        foreach (obs_hit_cnt[i]) chk({tag, "_cnt_at_hit"}, obs_hit_cnt[i], min_int(i + 1, CMAX_L));

        chk({tag, "_ndone"}, done_cyc.size(), 1);
        if (done_cyc.size() == 1 && obs_bit_cyc.size() == nb) begin
            chk({tag, "_done_time"}, done_cyc[0], obs_bit_cyc[nb-1] + 1);
            chk({tag, "_cnt_at_done"}, done_cnt[0], min_int(exp_hits, CMAX_L));
        end
        chk({tag, "_cnt_held"}, match_count, min_int(exp_hits, CMAX_L));
        chk({tag, "_cnt_sat"}, match_count_s, min_int(exp_hits, CMAX_S));
        chk({tag, "_hits_sat_inst"}, hit_s_n, exp_hits);

        mon_en = 1'b0;
        $display("frame %s pat=%b ovl=%0d words=%0d hits=%0d count=%0d", tag, pat, ovl, nw,
                 obs_hit_cyc.size(), match_count);
    endtask

    initial begin
        int nw;
        logic [3:0] pat;
        logic ovl;

        foreach (fr_gap[i]) fr_gap[i] = 0;

        // ---- reset
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("after_reset");
        $display("reset released, outputs idle");

        // ---- overlap, non-overlap, cross-word, backpressure, saturation
        fr_words[0] = 8'hB6;
        run_frame("overlap", 4'b1011, 1'b1, 1);
        run_frame("non_overlap", 4'b1011, 1'b0, 1);

        fr_words[0] = 8'h01; fr_words[1] = 8'h60;
        run_frame("cross_word", 4'b1011, 1'b1, 2);
        fr_gap[1] = 11;
        run_frame("backpressure", 4'b1011, 1'b1, 2);
        fr_gap[1] = 0;

        fr_words[0] = 8'hFF;
        run_frame("saturation", 4'b1111, 1'b1, 1);

        // ---- randomized frames
        for (int r = 0; r < 10; r++) begin
            pat = 4'($urandom_range(0, 15));
            ovl = 1'($urandom_range(0, 1));
            nw  = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                fr_words[w] = 8'($urandom);
                fr_gap[w] = (w > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, 12) : 0;
            end
            run_frame("random", pat, ovl, nw);
        end
        foreach (fr_gap[i]) fr_gap[i] = 0;

        // ---- abort on the 4th SHIFT bit, which would otherwise hit
        cfg_pattern = 4'b1011; cfg_overlap = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_data = 8'hB6; s_last = 1'b1; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_pre_bit", {bit_valid, bit_out}, 2'b11);
        abort = 1'b1; s_valid = 1'b1; s_data = 8'hFF;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle", {busy, done, hit}, 3'b000);
        chk("abort_cnt", match_count, 16'd0);
        for (int i = 0; i < 6; i++) begin
            chk("abort_quiet", {s_ready, bit_valid, hit, done, busy}, 5'b00000);
            @(posedge clk); #1;
        end
        chk("abort_cnt_held", match_count, 16'd0);
        s_valid = 1'b0;
        $display("abort step: busy=%0d count=%0d", busy, match_count);

        // ---- start and abort together: abort wins
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {busy, s_ready}, 2'b00);
        $display("start+abort step: busy=%0d", busy);

        // ---- asynchronous reset mid-frame
        cfg_pattern = 4'b1111; cfg_overlap = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_data = 8'hFF; s_last = 1'b1; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        chk("pre_reset_cnt", match_count, 16'd3);
        chk("pre_reset_ctl", {busy, bit_valid, hit}, 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        #20;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("post_async_reset");
        $display("async reset step: count=%0d busy=%0d", match_count, busy);

        // ---- a clean frame after reset still works
        fr_words[0] = 8'hB6;
        run_frame("after_reset_frame", 4'b1011, 1'b1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
